// File: rtl/decade_cascade_display.sv
// decade_cascade_display
//   Extends a single-digit up/down decade counter to three BCD digits by
//   watching the incoming digit for carry (9->0) and borrow (0->9), and
//   drives a time-multiplexed, active-low, 3-digit seven-segment display.
//
// Parameters
//   SCAN_DIV  clocks each digit stays lit before the scan advances (>= 2)
//   LZB       1 = blank leading-zero hundreds/tens, 0 = always show
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   number     ones digit from the upstream counter (0..9 legal)
//   zero       upstream flag, 1 when number == 0
//   value_bcd  {hundreds, tens, ones}, registered
//   wrap       one-cycle pulse on 999->000 or 000->999
//   seg        segments, active-low, seg[0]=a .. seg[6]=g
//   an         digit enables, active-low one-hot, an[0]=ones
module decade_cascade_display #(
  parameter int SCAN_DIV = 4,
  parameter bit LZB      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  number,
  input  logic        zero,
  output logic [11:0] value_bcd,
  output logic        wrap,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int              DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       prev_num;
  logic [3:0]       ones;
  logic [3:0]       tens;
  logic [3:0]       hund;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       scan_idx;

  logic             carry;
  logic             borrow;
  logic [3:0]       tens_nxt;
  logic [3:0]       hund_nxt;
  logic             wrap_nxt;
  logic [3:0]       digit;
  logic             blank;
  logic [2:0]       an_nxt;
  logic [6:0]       seg_nxt;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = 7'h7F;
    endcase
  endfunction

  // Carry needs the upstream zero flag as well; an out-of-range prev_num
  // can never match 9 or 0, so invalid digits never cascade.
  always_comb begin
    carry    = (prev_num == 4'd9) && (number == 4'd0) && zero;
    borrow   = (prev_num == 4'd0) && (number == 4'd9);
    tens_nxt = tens;
    hund_nxt = hund;
    wrap_nxt = 1'b0;
    if (carry) begin
      if (tens == 4'd9) begin
        tens_nxt = 4'd0;
        if (hund == 4'd9) begin
          hund_nxt = 4'd0;
          wrap_nxt = 1'b1;
        end else begin
          hund_nxt = hund + 4'd1;
        end
      end else begin
        tens_nxt = tens + 4'd1;
      end
    end else if (borrow) begin
      if (tens == 4'd0) begin
        tens_nxt = 4'd9;
        if (hund == 4'd0) begin
          hund_nxt = 4'd9;
          wrap_nxt = 1'b1;
        end else begin
          hund_nxt = hund - 4'd1;
        end
      end else begin
        tens_nxt = tens - 4'd1;
      end
    end
  end

  // Blanked digits keep their anode slot so every digit gets equal duty.
  always_comb begin
    case (scan_idx)
      2'd1: begin
        digit  = tens;
        blank  = LZB && (hund == 4'd0) && (tens == 4'd0);
        an_nxt = 3'b101;
      end
      2'd2: begin
        digit  = hund;
        blank  = LZB && (hund == 4'd0);
        an_nxt = 3'b011;
      end
      default: begin
        digit  = ones;
        blank  = 1'b0;
        an_nxt = 3'b110;
      end
    endcase
    seg_nxt = blank ? 7'h7F : glyph(digit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_num <= 4'd0;
      ones     <= 4'd0;
      tens     <= 4'd0;
      hund     <= 4'd0;
      wrap     <= 1'b0;
      div_cnt  <= '0;
      scan_idx <= 2'd0;
      an       <= 3'b110;
      seg      <= 7'h40;
    end else begin
      prev_num <= number;
      ones     <= number;
      tens     <= tens_nxt;
      hund     <= hund_nxt;
      wrap     <= wrap_nxt;
      an       <= an_nxt;
      seg      <= seg_nxt;
      if (div_cnt == DIV_LAST) begin
        div_cnt  <= '0;
        scan_idx <= (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign value_bcd = {hund, tens, ones};

endmodule

// File: tb/tb_decade_cascade_display.sv
module tb_decade_cascade_display;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  number = 4'd0;
  logic        zero = 1'b1;
  logic [11:0] value_bcd, value_bcd_n;
  logic        wrap, wrap_n;
  logic [6:0]  seg, seg_n;
  logic [2:0]  an, an_n;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: the upper two digits as an integer 0..99.
  int          upper;
  int          prev_n;
  logic        exp_wrap;
  logic [11:0] exp_bcd;
  logic [11:0] prev_bcd;

  decade_cascade_display #(.SCAN_DIV(SCAN_DIV), .LZB(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .number(number), .zero(zero),
    .value_bcd(value_bcd), .wrap(wrap), .seg(seg), .an(an)
  );

  decade_cascade_display #(.SCAN_DIV(SCAN_DIV), .LZB(1'b0)) dut_nlzb (
    .clk(clk), .rst_n(rst_n), .number(number), .zero(zero),
    .value_bcd(value_bcd_n), .wrap(wrap_n), .seg(seg_n), .an(an_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic void model_reset();
    upper    = 0;
    prev_n   = 0;
    exp_wrap = 1'b0;
    exp_bcd  = 12'h000;
    prev_bcd = 12'h000;
  endfunction

  function automatic void model_apply(input int n);
    prev_bcd = exp_bcd;
    exp_wrap = 1'b0;
    if (prev_n == 9 && n == 0) begin
      if (upper == 99) exp_wrap = 1'b1;
      upper = (upper + 1) % 100;
    end else if (prev_n == 0 && n == 9) begin
      if (upper == 0) exp_wrap = 1'b1;
      upper = (upper + 99) % 100;
    end
    prev_n  = n;
    exp_bcd = {4'(upper / 10), 4'(upper % 10), 4'(n)};
  endfunction

  function automatic int exp_idx();
    return (cyc == 0) ? 0 : ((cyc - 1) / SCAN_DIV) % 3;
  endfunction

  function automatic logic [2:0] exp_an(input int idx);
    return ~(3'b001 << idx);
  endfunction

  function automatic logic [6:0] exp_seg(input logic [11:0] v, input int idx, input bit lzb);
    logic [3:0] h, t, o, d;
    h = v[11:8];
    t = v[7:4];
    o = v[3:0];
    d = (idx == 0) ? o : (idx == 1) ? t : h;
    if (lzb && ((idx == 2 && h == 0) || (idx == 1 && h == 0 && t == 0))) return 7'h7F;
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic drive(input logic [3:0] n);
    @(negedge clk);
    number = n;
    zero   = (n == 4'd0);
    @(posedge clk);
    model_apply(int'(n));
    #1;
  endtask

  task automatic do_reset(input logic [3:0] n);
    @(negedge clk);
    rst_n  = 1'b0;
    number = n;
    zero   = (n == 4'd0);
    repeat (3) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_apply(int'(n));
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    number = 4'd5;
    zero   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    checks++; if (value_bcd !== 12'h000) begin failures++; $display("FAIL reset_value got=%h exp=000", value_bcd); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    checks++; if (an !== 3'b110) begin failures++; $display("FAIL reset_an got=%b exp=110", an); end
    checks++; if (seg !== 7'h40) begin failures++; $display("FAIL reset_seg got=%h exp=40", seg); end
    checks++; if (seg_n !== 7'h40) begin failures++; $display("FAIL reset_seg_nlzb got=%h exp=40", seg_n); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_apply(5);
    #1;
    checks++; if (value_bcd !== 12'h005) begin failures++; $display("FAIL release_value got=%h exp=005", value_bcd); end
    drive(4'd6);
    drive(4'd0);
    // Reset with number=9 after 0 would otherwise borrow to 999.
    @(negedge clk);
    rst_n  = 1'b0;
    number = 4'd9;
    zero   = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    checks++; if (value_bcd !== 12'h000) begin failures++; $display("FAIL midreset_value got=%h exp=000", value_bcd); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL midreset_wrap got=%b exp=0", wrap); end
    @(negedge clk);
    rst_n = 1'b1;
    number = 4'd0;
    zero   = 1'b1;
    @(posedge clk);
    model_apply(0);
    #1;
  endtask

  task automatic test_carry();
    int wraps = 0;
    do_reset(4'd0);
    for (int k = 1; k <= 1000; k++) begin
      drive(4'(k % 10));
      if (wrap === 1'b1) wraps++;
      checks++; if (value_bcd !== exp_bcd) begin failures++; $display("FAIL carry_value step=%0d got=%h exp=%h", k, value_bcd, exp_bcd); end
      checks++; if (wrap !== exp_wrap) begin failures++; $display("FAIL carry_wrap step=%0d got=%b exp=%b", k, wrap, exp_wrap); end
      if (k == 100) begin
        checks++; if (value_bcd !== 12'h100) begin failures++; $display("FAIL carry_099_100 got=%h exp=100", value_bcd); end
      end
    end
    checks++; if (wraps != 1) begin failures++; $display("FAIL carry_wrap_count got=%0d exp=1", wraps); end
    checks++; if (value_bcd !== 12'h000) begin failures++; $display("FAIL carry_final got=%h exp=000", value_bcd); end
  endtask

  task automatic test_borrow();
    do_reset(4'd0);
    drive(4'd9);
    checks++; if (value_bcd !== 12'h999) begin failures++; $display("FAIL borrow_first got=%h exp=999", value_bcd); end
    checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL borrow_wrap got=%b exp=1", wrap); end
    drive(4'd8);
    checks++; if (value_bcd !== 12'h998) begin failures++; $display("FAIL borrow_second got=%h exp=998", value_bcd); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL borrow_wrap_clear got=%b exp=0", wrap); end
    for (int d = 7; d >= -1; d--) begin
      drive(4'((d + 10) % 10));
      checks++; if (value_bcd !== exp_bcd) begin failures++; $display("FAIL borrow_walk got=%h exp=%h", value_bcd, exp_bcd); end
    end
    checks++; if (value_bcd !== 12'h989) begin failures++; $display("FAIL borrow_989 got=%h exp=989", value_bcd); end
  endtask

  task automatic test_reversal();
    do_reset(4'd0);
    for (int d = 1; d <= 8; d++) drive(4'(d));
    drive(4'd9); drive(4'd8); drive(4'd9);
    checks++; if (value_bcd !== 12'h009) begin failures++; $display("FAIL reversal_hold got=%h exp=009", value_bcd); end
    drive(4'd0);
    checks++; if (value_bcd !== 12'h010) begin failures++; $display("FAIL reversal_carry got=%h exp=010", value_bcd); end
    drive(4'd9);
    checks++; if (value_bcd !== 12'h009) begin failures++; $display("FAIL reversal_borrow got=%h exp=009", value_bcd); end
    drive(4'd0);
    checks++; if (value_bcd !== 12'h010) begin failures++; $display("FAIL reversal_net got=%h exp=010", value_bcd); end
  endtask

  task automatic test_scan();
    logic [6:0] e1, e0;
    do_reset(4'd7);
    for (int i = 0; i < 24; i++) begin
      drive(4'd7);
      e1 = (exp_idx() == 0) ? 7'h78 : 7'h7F;
      e0 = (exp_idx() == 0) ? 7'h78 : 7'h40;
      checks++; if (an !== exp_an(exp_idx())) begin failures++; $display("FAIL scan_an cyc=%0d got=%b exp=%b", cyc, an, exp_an(exp_idx())); end
      checks++; if (seg !== e1) begin failures++; $display("FAIL scan_seg_lzb cyc=%0d got=%h exp=%h", cyc, seg, e1); end
      checks++; if (seg_n !== e0) begin failures++; $display("FAIL scan_seg_nolzb cyc=%0d got=%h exp=%h", cyc, seg_n, e0); end
    end
  endtask

  task automatic test_invalid();
    bit seen = 0;
    do_reset(4'd0);
    for (int d = 1; d <= 10; d++) drive(4'(d % 10));
    checks++; if (value_bcd !== 12'h010) begin failures++; $display("FAIL invalid_setup got=%h exp=010", value_bcd); end
    drive(4'd12);
    checks++; if (value_bcd !== 12'h01C) begin failures++; $display("FAIL invalid_capture got=%h exp=01c", value_bcd); end
    for (int i = 0; i < 12 && !seen; i++) begin
      drive(4'd12);
      if (an === 3'b110) begin
        seen = 1;
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL invalid_blank got=%h exp=7f", seg); end
      end
    end
    if (!seen) begin
      checks++; failures++; $display("FAIL invalid_scan_timeout an never reached 110");
    end
    drive(4'd0);
    checks++; if (value_bcd !== 12'h010) begin failures++; $display("FAIL invalid_no_carry got=%h exp=010", value_bcd); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL invalid_wrap got=%b exp=0", wrap); end
  endtask

  task automatic test_random();
    int r, n;
    logic [6:0] e1, e0;
    do_reset(4'd0);
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45)      n = (prev_n + 1) % 10;
      else if (r < 90) n = (prev_n + 9) % 10;
      else if (r < 96) n = prev_n;
      else             n = int'($urandom_range(10, 15));
      drive(4'(n));
      e1 = exp_seg(prev_bcd, exp_idx(), 1'b1);
      e0 = exp_seg(prev_bcd, exp_idx(), 1'b0);
      checks++; if (value_bcd !== exp_bcd) begin failures++; $display("FAIL rand_value i=%0d got=%h exp=%h", i, value_bcd, exp_bcd); end
      checks++; if (wrap !== exp_wrap) begin failures++; $display("FAIL rand_wrap i=%0d got=%b exp=%b", i, wrap, exp_wrap); end
      checks++; if (an !== exp_an(exp_idx())) begin failures++; $display("FAIL rand_an i=%0d got=%b exp=%b", i, an, exp_an(exp_idx())); end
      checks++; if (seg !== e1) begin failures++; $display("FAIL rand_seg_lzb i=%0d got=%h exp=%h", i, seg, e1); end
      checks++; if (seg_n !== e0) begin failures++; $display("FAIL rand_seg_nolzb i=%0d got=%h exp=%h", i, seg_n, e0); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_carry();
    test_borrow();
    test_reversal();
    test_scan();
    test_invalid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decade_cascade_display.md
Name: decade_cascade_display

Overview:
- Downstream consumer of the single-digit up/down decade counter (outputs number[3:0], zero).
- Extends the count to three BCD digits by detecting carry (9->0) and borrow (0->9) on the incoming digit.
- Drives a time-multiplexed, active-low, 3-digit seven-segment display.
- Sits between the counter and the board display pins; also exports the full BCD value and a wrap pulse.

Parameters:
SCAN_DIV, 4, clock cycles each digit stays lit before the scan advances (legal >= 2)
LZB, 1, leading-zero blanking enable (1 = blank leading-zero hundreds/tens, 0 = always show)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, synchronous, active-low
number  input  4  ones digit from upstream counter (0..9 legal)
zero  input  1  upstream flag, 1 when number==0
value_bcd  output  12  {hundreds, tens, ones}, registered
wrap  output  1  one-cycle pulse on 999->000 or 000->999
seg  output  7  segments, active-low, seg[0]=a .. seg[6]=g
an  output  3  digit enables, active-low one-hot, an[0]=ones

Behaviour:
- Reset: one clock, synchronous, active-low; all state is sampled on the rising clk edge while rst_n==0.
- Reset values:
  - prev_num = 0; ones/tens/hund = 0; value_bcd = 12'h000; wrap = 0.
  - div_cnt = 0; scan_idx = 0; an = 3'b110; seg = 7'h40 (glyph 0).
- Reset asserted mid-operation overrides every update in that cycle.
- Input capture: ones <= number each cycle; prev_num <= number each cycle.
- Carry: prev_num==9 && number==0 && zero==1.
  - In the same edge that captures ones=0, tens increments.
  - If tens==9: tens -> 0 and hund increments.
  - If hund==9 too: hund -> 0 and wrap = 1 for one cycle.
- Borrow: prev_num==0 && number==9.
  - Tens decrements.
  - If tens==0: tens -> 9 and hund decrements.
  - If hund==0 too: hund -> 9 and wrap = 1 for one cycle.
- Carry and borrow are mutually exclusive by construction.
- No other transition (hold, +/-1 inside 0..9, direction reversal) touches tens/hund.
- Input number > 9: ones captures it unchanged, no carry/borrow, and the digit displays blank (seg = 7'h7F).
- Latency: value_bcd equals {hund, tens, ones} registered, so it changes 1 cycle after number. Tens/hund update on the same edge as ones, so value_bcd never shows an intermediate value (e.g. 109 -> 110, never 100).
- Scan:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - When div_cnt==SCAN_DIV-1, scan_idx advances 0->1->2->0.
- Display registers:
  - an and seg are registered from scan_idx and the current digit registers.
  - They lag scan_idx by 1 cycle and always stay coherent with each other.
  - an: idx0 = 110, idx1 = 101, idx2 = 011.
- Glyphs (active-low, hex gfedcba): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10; blank:7F.
- Leading-zero blanking, LZB=1:
  - The hundreds digit is blank when hund==0.
  - The tens digit is blank when hund==0 && tens==0.
  - The ones digit is never blank.
  - The anode still cycles for blanked digits, so duty cycle is uniform.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks with number=5 -> value_bcd=000, seg=7'h40, an=3'b110, wrap=0. Release -> next edge value_bcd=005.
- Carry chain: drive number 0..9,0 repeatedly (upstream mode=1) from 000 for 1000 steps -> value_bcd counts 000..999 then 000. wrap=1 for exactly one cycle, coincident with 000. No intermediate value at 099->100.
- Borrow chain: from 000 drive number 9,8,..0,9 (mode=0) -> first step gives value_bcd=999 with wrap=1, then 998.
- Direction reversal: number 8,9,8,9,0 -> tens unchanged until the final 9->0, then tens+1 once. Sequence 0,9,0 -> one borrow then one carry, net tens unchanged.
- Scan/LZB with SCAN_DIV=4, LZB=1, value 007:
  - an cycles 110,101,011, each for 4 clocks.
  - seg = 78, 7F, 7F respectively.
  - With LZB=0, seg = 78, 40, 40.
- Invalid input: number=12 -> no tens change, ones digit seg=7'h7F; next number=0 -> no carry (prev_num was 12).
